// File: rtl/can_stuff_pkg.sv
// Shared types and constants for the CAN bit-stuffing engine.
//   stuff_mode_e       : engine direction (TX insert / RX remove)
//   CAN_RECESSIVE      : idle / reset bus level
//   DEF_RUN_LEN        : default run length that triggers a stuff bit
//   DEF_FIXED_INTERVAL : default data bits between fixed stuff bits
//   STUFF_CNT_W        : width of the modulo-8 stuff counter
package can_stuff_pkg;

  typedef enum logic {
    STUFF_TX = 1'b0,
    STUFF_RX = 1'b1
  } stuff_mode_e;

  localparam logic        CAN_RECESSIVE      = 1'b1;
  localparam int unsigned DEF_RUN_LEN        = 5;
  localparam int unsigned DEF_FIXED_INTERVAL = 4;
  localparam int unsigned STUFF_CNT_W        = 3;

endpackage

// File: rtl/can_run_tracker.sv
// Tracks the value and length of the current run of identical bits.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : synchronous return to the reset state
//   step        : a data bit joins (or starts) the run
//   restart     : force a new run of length 1 starting with cur_bit
//   zero        : drop the run (stuffing region inactive)
//   cur_bit     : bit applied by step / restart
//   last_bit    : value of the current run
//   run_hit     : run length equals RUN_LEN
//   step_hit_c  : stepping cur_bit this cycle would make the run reach RUN_LEN
module can_run_tracker
  import can_stuff_pkg::*;
#(
  parameter int unsigned RUN_LEN = DEF_RUN_LEN,
  parameter int unsigned CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic step,
  input  logic restart,
  input  logic zero,
  input  logic cur_bit,
  output logic last_bit,
  output logic run_hit,
  output logic step_hit_c
);

  logic [CNT_W-1:0] run_cnt;

  // Run state; restart has priority so a stuff bit always begins a fresh run.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      last_bit <= CAN_RECESSIVE;
      run_cnt  <= '0;
    end else if (restart) begin
      last_bit <= cur_bit;
      run_cnt  <= CNT_W'(1);
    end else if (step) begin
      last_bit <= cur_bit;
      run_cnt  <= (cur_bit == last_bit && run_cnt != '0) ? run_cnt + CNT_W'(1) : CNT_W'(1);
    end else if (zero) begin
      run_cnt  <= '0;
    end
  end

  assign run_hit    = (run_cnt == CNT_W'(RUN_LEN));
  // RUN_LEN >= 2, so run_cnt == RUN_LEN-1 already implies a non-empty run.
  assign step_hit_c = (cur_bit == last_bit) && (run_cnt == CNT_W'(RUN_LEN - 1));

endmodule

// File: rtl/can_bit_stuff_engine.sv
// Bidirectional CAN bit-stuffing engine, one bit per valid/ready handshake.
// TX inserts a complement stuff bit after RUN_LEN identical bits; RX removes
// it and pulses stuff_err when the removed bit does not toggle.
// Optional macro CAN_FIXED_STUFF_EN adds CAN FD fixed stuffing (fixed_stuff).
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   mode_rx            : 0 = TX stuff, 1 = RX destuff (change only when idle)
//   stuff_en           : dynamic stuffing region active
//   fixed_stuff        : fixed-stuff region (used only with CAN_FIXED_STUFF_EN)
//   clear              : synchronous flush / frame abort
//   in_valid/in_bit/in_ready            : upstream bit stream
//   out_valid/out_bit/out_is_stuff/out_ready : downstream bit stream
//   stuff_err          : one-cycle RX stuff violation pulse
//   stuff_cnt          : dynamic stuff bits inserted/removed, modulo 8
module can_bit_stuff_engine
  import can_stuff_pkg::*;
#(
  parameter int unsigned RUN_LEN        = DEF_RUN_LEN,
  parameter int unsigned FIXED_INTERVAL = DEF_FIXED_INTERVAL,
  parameter int unsigned CNT_W          = $clog2(RUN_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode_rx,
  input  logic                   stuff_en,
  input  logic                   fixed_stuff,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_bit,
  output logic                   out_is_stuff,
  input  logic                   out_ready,
  output logic                   stuff_err,
  output logic [STUFF_CNT_W-1:0] stuff_cnt
);

  stuff_mode_e mode;
  logic        pend_stuff;
  logic        last_bit, run_hit, step_hit_c;

  logic is_rx_c, slot_free_c, fix_on_c, dyn_on_c, fixed_hit_c;
  logic pend_any_c, in_ready_c, in_fire_c;
  logic rx_stuff_c, rx_fix_c, drop_c, emit_c, data_c;
  logic trk_step_c, trk_restart_c, trk_zero_c, trk_bit_c;

  assign mode = stuff_mode_e'(mode_rx);

`ifdef CAN_FIXED_STUFF_EN
  localparam int unsigned FIX_W = $clog2(FIXED_INTERVAL + 1);

  logic [FIX_W-1:0] fixed_cnt;

  assign fix_on_c    = fixed_stuff;
  // TX: a fixed stuff bit is owed; RX: the next accepted bit is a fixed stuff bit.
  assign fixed_hit_c = fixed_stuff && (fixed_cnt == FIX_W'(FIXED_INTERVAL));

  // Data bits since the last fixed stuff bit; held at zero outside the region.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || !fixed_stuff) begin
      fixed_cnt <= '0;
    end else if ((emit_c && !pend_stuff) || rx_fix_c) begin
      fixed_cnt <= '0;
    end else if (data_c) begin
      fixed_cnt <= fixed_cnt + FIX_W'(1);
    end
  end
`else
  logic unused_fixed;

  assign fix_on_c     = 1'b0;
  assign fixed_hit_c  = 1'b0;
  assign unused_fixed = fixed_stuff ^ (FIXED_INTERVAL == 0);
`endif

  // Handshake decode and run-tracker control.
  always_comb begin
    is_rx_c       = (mode == STUFF_RX);
    slot_free_c   = !out_valid || out_ready;
    dyn_on_c      = stuff_en && !fix_on_c;
    pend_any_c    = !is_rx_c && (pend_stuff || fixed_hit_c);
    in_ready_c    = slot_free_c && !pend_any_c;
    in_fire_c     = in_valid && in_ready_c;
    rx_stuff_c    = is_rx_c && in_fire_c && dyn_on_c && run_hit;
    rx_fix_c      = is_rx_c && in_fire_c && fixed_hit_c;
    drop_c        = rx_stuff_c || rx_fix_c;
    emit_c        = pend_any_c && slot_free_c;
    data_c        = in_fire_c && !drop_c;
    // Stuff bits (inserted or removed) and fixed-region data only record the
    // latest bit value; they never extend a dynamic run.
    trk_restart_c = emit_c || drop_c || (data_c && fix_on_c);
    trk_step_c    = data_c && dyn_on_c;
    trk_zero_c    = data_c && !stuff_en && !fix_on_c;
    trk_bit_c     = emit_c ? !last_bit : in_bit;
  end

  assign in_ready = in_ready_c;

  can_run_tracker #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) u_run (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (clear),
    .step       (trk_step_c),
    .restart    (trk_restart_c),
    .zero       (trk_zero_c),
    .cur_bit    (trk_bit_c),
    .last_bit   (last_bit),
    .run_hit    (run_hit),
    .step_hit_c (step_hit_c)
  );

  // Output register, pending-stuff flag, error pulse and stuff counter.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      out_valid    <= 1'b0;
      out_bit      <= CAN_RECESSIVE;
      out_is_stuff <= 1'b0;
      stuff_err    <= 1'b0;
      stuff_cnt    <= '0;
      pend_stuff   <= 1'b0;
    end else begin
      stuff_err <= drop_c && (in_bit == last_bit);

      if (emit_c) begin
        out_valid    <= 1'b1;
        out_bit      <= !last_bit;
        out_is_stuff <= 1'b1;
      end else if (data_c) begin
        out_valid    <= 1'b1;
        out_bit      <= in_bit;
        out_is_stuff <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid    <= 1'b0;
        out_is_stuff <= 1'b0;
      end

      // A pending dynamic stuff bit survives stuff_en falling.
      if (emit_c && pend_stuff) begin
        pend_stuff <= 1'b0;
      end else if (!is_rx_c && trk_step_c && step_hit_c) begin
        pend_stuff <= 1'b1;
      end

      if ((emit_c && pend_stuff) || rx_stuff_c) begin
        stuff_cnt <= stuff_cnt + STUFF_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_can_bit_stuff_engine.sv
// Directed self-checking bench for can_bit_stuff_engine.
module tb_can_bit_stuff_engine;
  import can_stuff_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, mode_rx, stuff_en, fixed_stuff, clear;
  logic       in_valid, in_bit, in_ready;
  logic       out_valid, out_bit, out_is_stuff, out_ready;
  logic       stuff_err;
  logic [2:0] stuff_cnt;

  int n_chk = 0;
  int n_err = 0;
  int nready, nerrp, cyc_n, stall_lo, stall_hi;
  bit stim[$];
  bit obs_b[$], obs_s[$], exp_b[$], exp_s[$];

  always #5 clk = ~clk;

  can_bit_stuff_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_rx      (mode_rx),
    .stuff_en     (stuff_en),
    .fixed_stuff  (fixed_stuff),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_bit      (out_bit),
    .out_is_stuff (out_is_stuff),
    .out_ready    (out_ready),
    .stuff_err    (stuff_err),
    .stuff_cnt    (stuff_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset(input logic rx, input logic en);
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b1; out_ready = 1'b1;
    mode_rx = rx; stuff_en = en; fixed_stuff = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_b.delete(); obs_s.delete(); exp_b.delete(); exp_s.delete(); stim.delete();
    nready = 0; nerrp = 0; cyc_n = 0; stall_lo = 0; stall_hi = 0;
  endtask

  // One clock with the current inputs; records output handshakes.
  task automatic cyc(output bit acc);
    out_ready = !(cyc_n >= stall_lo && cyc_n < stall_hi);
    #1;
    acc = in_valid && in_ready;
    if (in_valid && !in_ready) nready++;
    if (out_valid && !out_ready && obs_b.size() < exp_b.size()) begin
      chk("hold_bit", out_bit, exp_b[obs_b.size()]);
      chk("hold_stuff", out_is_stuff, exp_s[obs_b.size()]);
    end
    if (out_valid && out_ready) begin
      obs_b.push_back(out_bit);
      obs_s.push_back(out_is_stuff);
    end
    @(posedge clk); #1;
    cyc_n++;
    if (stuff_err) nerrp++;
  endtask

  task automatic send();
    bit acc;
    int n;
    foreach (stim[i]) begin
      in_valid = 1'b1;
      in_bit   = stim[i];
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
        cyc(acc);
        n++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    stim.delete();
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) cyc(acc);
  endtask

  task automatic push_n(input bit v, input int n, input bit to_exp);
    for (int i = 0; i < n; i++) begin
      if (to_exp) begin
        exp_b.push_back(v);
        exp_s.push_back(1'b0);
      end else begin
        stim.push_back(v);
      end
    end
  endtask

  task automatic push_stuff(input bit v);
    exp_b.push_back(v);
    exp_s.push_back(1'b1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      chk($sformatf("%s_bit%0d", tag, i), obs_b[i], exp_b[i]);
      chk($sformatf("%s_stf%0d", tag, i), obs_s[i], exp_s[i]);
    end
  endtask

  initial begin
    bit acc;

    // Reset state
    do_reset(1'b0, 1'b1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 1);
    chk("rst_out_is_stuff", out_is_stuff, 0);
    chk("rst_stuff_err", stuff_err, 0);
    chk("rst_stuff_cnt", stuff_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // TX: six recessive bits -> stuff after the fifth
    push_n(1'b1, 6, 1'b0);
    push_n(1'b1, 5, 1'b1); push_stuff(1'b0); push_n(1'b1, 1, 1'b1);
    send(); idle(4);
    cmp_stream("tx6");
    chk("tx6_ready_low", nready, 1);
    chk("tx6_cnt", stuff_cnt, 1);

    // RX: stuff bit removed, no error
    do_reset(1'b1, 1'b1);
    stim = '{0, 0, 0, 0, 0, 1, 0};
    push_n(1'b0, 6, 1'b1);
    send(); idle(4);
    cmp_stream("rx_ok");
    chk("rx_ok_err", nerrp, 0);
    chk("rx_ok_cnt", stuff_cnt, 1);

    // RX: sixth identical bit is a stuff violation
    do_reset(1'b1, 1'b1);
    push_n(1'b1, 6, 1'b0);
    push_n(1'b1, 5, 1'b1);
    send(); idle(4);
    cmp_stream("rx_bad");
    chk("rx_bad_err_cycles", nerrp, 1);
    chk("rx_bad_cnt", stuff_cnt, 1);

    // TX with a 3-cycle downstream stall while the stuff bit is presented
    do_reset(1'b0, 1'b1);
    stall_lo = 6; stall_hi = 9;
    stim = '{1, 1, 1, 1, 1, 1, 0, 0};
    push_n(1'b1, 5, 1'b1); push_stuff(1'b0); push_n(1'b1, 1, 1'b1); push_n(1'b0, 2, 1'b1);
    send(); idle(4);
    cmp_stream("tx_stall");
    chk("tx_stall_cnt", stuff_cnt, 1);

    // TX: clear in the cycle the stuff bit would be emitted
    do_reset(1'b0, 1'b1);
    push_n(1'b0, 5, 1'b0);
    send();
    clear = 1'b1;
    cyc(acc);
    clear = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_out_is_stuff", out_is_stuff, 0);
    chk("clr_stuff_cnt", stuff_cnt, 0);
    obs_b.delete(); obs_s.delete();
    push_n(1'b0, 4, 1'b0);
    push_n(1'b0, 4, 1'b1);
    send(); idle(4);
    cmp_stream("clr_after");
    chk("clr_after_cnt", stuff_cnt, 0);

    // stuff_en=0: plain pass-through
    do_reset(1'b0, 1'b0);
    push_n(1'b1, 7, 1'b0);
    push_n(1'b1, 7, 1'b1);
    send(); idle(3);
    cmp_stream("pass");
    chk("pass_cnt", stuff_cnt, 0);

    // Pending stuff bit still emitted after stuff_en falls
    do_reset(1'b0, 1'b1);
    push_n(1'b1, 5, 1'b0);
    push_n(1'b1, 5, 1'b1); push_stuff(1'b0); push_n(1'b1, 2, 1'b1);
    send();
    stuff_en = 1'b0;
    push_n(1'b1, 2, 1'b0);
    send(); idle(4);
    cmp_stream("en_fall");
    chk("en_fall_cnt", stuff_cnt, 1);

    // Nine stuff bits: counter wraps 7 -> 0 -> 1
    do_reset(1'b0, 1'b1);
    push_n(1'b1, 5, 1'b0);
    for (int k = 0; k < 8; k++) push_n(k[0], 4, 1'b0);
    send(); idle(4);
    chk("wrap_len", obs_b.size(), 46);
    chk("wrap_cnt", stuff_cnt, 1);

`ifdef CAN_FIXED_STUFF_EN
    // Fixed stuffing every 4 data bits, stuff_cnt untouched
    do_reset(1'b0, 1'b1);
    fixed_stuff = 1'b1;
    stim = '{1, 0, 1, 0, 1, 0, 1, 0};
    exp_b = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    exp_s = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    send(); idle(4);
    cmp_stream("fixed");
    chk("fixed_cnt", stuff_cnt, 0);
    fixed_stuff = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
